// File: rtl/seq_chunk_adder_if.sv
// Handshake and data bundle for seq_chunk_adder: requester drives start/operands,
// the adder returns busy/done/sum/cout.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 128
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder built on one CHUNK-bit slice, LSB chunk first.
// Define CHUNK_ADDER_SUB_EN to enable subtraction through the sub input.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned CHUNK = 32
) (
  input logic              clk,
  input logic              rst,
  seq_chunk_adder_if.slave bus
);
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned BaseW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NCHUNK - 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic             carry_init;
  logic [BaseW-1:0] base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;

  assign base    = BaseW'(32'(idx_q) * CHUNK);
  assign a_chunk = a_q[base +: CHUNK];

`ifdef CHUNK_ADDER_SUB_EN
  logic sub_q, sub_d;

  always_comb begin
    sub_d = sub_q;
    if (state_q == StIdle && bus.start) begin
      sub_d = bus.sub;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end

  // a - b - cin == a + ~b + ~cin in two's complement
  assign carry_init = bus.cin ^ bus.sub;
  assign b_chunk    = b_q[base +: CHUNK] ^ {CHUNK{sub_q}};
`else
  logic unused_sub;
  assign unused_sub = bus.sub;
  assign carry_init = bus.cin;
  assign b_chunk    = b_q[base +: CHUNK];
`endif

  assign chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = carry_init;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[base +: CHUNK] = chunk_res[CHUNK-1:0];
        carry_d              = chunk_res[CHUNK];
        if (idx_q == LastIdx) begin
          cout_d  = chunk_res[CHUNK];
          idx_d   = '0;
          state_d = StFin;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = (state_q == StFin);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: three instances (CHUNK = 32, 128, 1) share operands
// but have separate start strobes.
module tb_seq_chunk_adder;
  localparam int unsigned W = 128;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  seq_chunk_adder_if #(.WIDTH(W)) if32 ();
  seq_chunk_adder_if #(.WIDTH(W)) ifw ();
  seq_chunk_adder_if #(.WIDTH(W)) if1 ();

  seq_chunk_adder #(.WIDTH(W), .CHUNK(32))  u_dut32 (.clk(clk), .rst(rst), .bus(if32));
  seq_chunk_adder #(.WIDTH(W), .CHUNK(128)) u_dutw  (.clk(clk), .rst(rst), .bus(ifw));
  seq_chunk_adder #(.WIDTH(W), .CHUNK(1))   u_dut1  (.clk(clk), .rst(rst), .bus(if1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic sub);
    if32.a = a; if32.b = b; if32.cin = cin; if32.sub = sub;
    ifw.a  = a; ifw.b  = b; ifw.cin  = cin; ifw.sub  = sub;
    if1.a  = a; if1.b  = b; if1.cin  = cin; if1.sub  = sub;
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       if32.start = v;
      1:       ifw.start  = v;
      default: if1.start  = v;
    endcase
  endtask

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return if32.busy;
      1:       return ifw.busy;
      default: return if1.busy;
    endcase
  endfunction

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return if32.done;
      1:       return ifw.done;
      default: return if1.done;
    endcase
  endfunction

  function automatic logic [W-1:0] get_sum(input int sel);
    case (sel)
      0:       return if32.sum;
      1:       return ifw.sum;
      default: return if1.sum;
    endcase
  endfunction

  function automatic logic get_cout(input int sel);
    case (sel)
      0:       return if32.cout;
      1:       return ifw.cout;
      default: return if1.cout;
    endcase
  endfunction

  // Issue one operation and return at the negedge where busy first drops.
  task automatic run_op(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, output logic [W-1:0] s,
                        output logic c, output int nbusy, output logic got_done,
                        output logic busy_at_done);
    @(negedge clk);
    set_ops(a, b, cin, sub);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    nbusy = 0;
    while (get_busy(sel) && nbusy < 300) begin
      nbusy++;
      @(negedge clk);
    end
    got_done     = get_done(sel);
    busy_at_done = get_busy(sel);
    s            = get_sum(sel);
    c            = get_cout(sel);
  endtask

  task automatic test_reset();
    set_ops('0, '0, 1'b0, 1'b0);
    if32.start = 1'b0; ifw.start = 1'b0; if1.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (if32.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", if32.busy); end
    n_checks++;
    if (if32.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", if32.done); end
    n_checks++;
    if (if32.sum !== '0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", if32.sum); end
    n_checks++;
    if (if32.cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b want 0", if32.cout); end
    n_checks++;
    if ({ifw.busy, ifw.done, if1.busy, if1.done} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_others: got %b want 0000", {ifw.busy, ifw.done, if1.busy, if1.done});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_basic();
    logic [W-1:0] s;
    logic         c, d, bz;
    int           nb;
    run_op(0, 128'd1205678900008765, 128'd4563456789087654, 1'b0, 1'b0, s, c, nb, d, bz);
    n_checks++;
    if (nb !== 4) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 4", nb); end
    n_checks++;
    if (d !== 1'b1 || bz !== 1'b0) begin n_fail++; $display("FAIL basic_done: got done=%b busy=%b want 1/0", d, bz); end
    n_checks++;
    if (s !== 128'd5769135689096419) begin n_fail++; $display("FAIL basic_sum: got %0d want 5769135689096419", s); end
    n_checks++;
    if (c !== 1'b0) begin n_fail++; $display("FAIL basic_cout: got %b want 0", c); end
    @(negedge clk);
    n_checks++;
    if (if32.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse: got %b want 0", if32.done); end
    n_checks++;
    if (if32.sum !== 128'd5769135689096419) begin n_fail++; $display("FAIL basic_sum_hold: got %0d want 5769135689096419", if32.sum); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] s, ones;
    logic         c, d, bz;
    int           nb;
    ones = '1;
    run_op(0, ones, 128'd3, 1'b0, 1'b0, s, c, nb, d, bz);
    n_checks++;
    if (d !== 1'b1 || s !== 128'd2 || c !== 1'b1) begin
      n_fail++; $display("FAIL wrap: got done=%b sum=%h cout=%b want 1/2/1", d, s, c);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s;
    logic         c, d, bz;
    int           nb;
    run_op(0, 128'd1013, 128'd1013, 1'b1, 1'b0, s, c, nb, d, bz);
    n_checks++;
    if (d !== 1'b1 || s !== 128'd2027 || c !== 1'b0) begin
      n_fail++; $display("FAIL b2b_first: got done=%b sum=%0d cout=%b want 1/2027/0", d, s, c);
    end
    // start raised during FIN must be ignored
    set_ops(128'd7, 128'd8, 1'b0, 1'b0);
    if32.start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if32.busy !== 1'b0 || if32.done !== 1'b0 || if32.sum !== 128'd2027) begin
      n_fail++; $display("FAIL b2b_fin_start: got busy=%b done=%b sum=%0d want 0/0/2027", if32.busy, if32.done, if32.sum);
    end
    @(negedge clk);
    if32.start = 1'b0;
    n_checks++;
    if (if32.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b want 1", if32.busy); end
    nb = 0;
    while (if32.busy && nb < 50) begin nb++; @(negedge clk); end
    n_checks++;
    if (nb !== 4 || if32.done !== 1'b1 || if32.sum !== 128'd15 || if32.cout !== 1'b0) begin
      n_fail++; $display("FAIL b2b_second: got cycles=%0d done=%b sum=%0d cout=%b want 4/1/15/0", nb, if32.done, if32.sum, if32.cout);
    end
  endtask

  task automatic test_busy_start_and_reset();
    int dn;
    int nb;
    @(negedge clk);
    set_ops(128'd100, 128'd23, 1'b0, 1'b0);
    if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    @(negedge clk);
    set_ops(128'd5, 128'd5, 1'b1, 1'b0);
    if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    nb = 0;
    while (!if32.done && nb < 50) begin nb++; @(negedge clk); end
    n_checks++;
    if (if32.done !== 1'b1 || if32.sum !== 128'd123 || if32.cout !== 1'b0) begin
      n_fail++; $display("FAIL busy_start_ignored: got done=%b sum=%0d cout=%b want 1/123/0", if32.done, if32.sum, if32.cout);
    end
    @(negedge clk);
    set_ops(128'd1013, 128'd1013, 1'b0, 1'b0);
    if32.start = 1'b1;
    @(negedge clk);
    if32.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (if32.busy !== 1'b0 || if32.done !== 1'b0 || if32.sum !== '0 || if32.cout !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got busy=%b done=%b sum=%h cout=%b want all 0", if32.busy, if32.done, if32.sum, if32.cout);
    end
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (if32.done === 1'b1) dn++;
    end
    n_checks++;
    if (dn !== 0) begin n_fail++; $display("FAIL mid_reset_no_done: got %0d done cycles want 0", dn); end
  endtask

`ifdef CHUNK_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] s, ones;
    logic         c, d, bz;
    int           nb;
    ones = '1;
    run_op(0, 128'd1013, 128'd1014, 1'b0, 1'b1, s, c, nb, d, bz);
    n_checks++;
    if (d !== 1'b1 || s !== ones || c !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow: got done=%b sum=%h cout=%b want 1/all-ones/0", d, s, c);
    end
    run_op(0, 128'd2027, 128'd1013, 1'b1, 1'b1, s, c, nb, d, bz);
    n_checks++;
    if (d !== 1'b1 || s !== 128'd1013 || c !== 1'b1) begin
      n_fail++; $display("FAIL sub_no_borrow: got done=%b sum=%0d cout=%b want 1/1013/1", d, s, c);
    end
  endtask
`else
  task automatic test_sub_ignored();
    logic [W-1:0] s;
    logic         c, d, bz;
    int           nb;
    run_op(0, 128'd5, 128'd3, 1'b0, 1'b1, s, c, nb, d, bz);
    n_checks++;
    if (d !== 1'b1 || s !== 128'd8 || c !== 1'b0) begin
      n_fail++; $display("FAIL sub_ignored: got done=%b sum=%0d cout=%b want 1/8/0", d, s, c);
    end
  endtask
`endif

  task automatic test_sweep();
    logic [W-1:0] va[5];
    logic [W-1:0] vb[5];
    logic         vc[5];
    logic [W-1:0] es[5];
    logic         ec[5];
    logic [W-1:0] s;
    logic         c, d, bz;
    int           nb;
    int           want_nb;
    va[0] = '1;                   vb[0] = 128'd3;                   vc[0] = 1'b0;
    es[0] = 128'd2;               ec[0] = 1'b1;
    va[1] = 128'd1205678900008765; vb[1] = 128'd4563456789087654;    vc[1] = 1'b0;
    es[1] = 128'd5769135689096419; ec[1] = 1'b0;
    va[2] = 128'd1013;            vb[2] = 128'd1013;                vc[2] = 1'b1;
    es[2] = 128'd2027;            ec[2] = 1'b0;
    va[3] = '1;                   vb[3] = '0;                       vc[3] = 1'b1;
    es[3] = '0;                   ec[3] = 1'b1;
    va[4] = 128'h0000_0000_ffff_ffff_0000_0000_ffff_ffff;
    vb[4] = 128'h0000_0000_0000_0001_0000_0000_0000_0001;            vc[4] = 1'b0;
    es[4] = 128'h0000_0001_0000_0000_0000_0001_0000_0000;            ec[4] = 1'b0;
    for (int sel = 1; sel <= 2; sel++) begin
      want_nb = (sel == 1) ? 1 : 128;
      for (int i = 0; i < 5; i++) begin
        run_op(sel, va[i], vb[i], vc[i], 1'b0, s, c, nb, d, bz);
        n_checks++;
        if (nb !== want_nb || d !== 1'b1 || bz !== 1'b0 || s !== es[i] || c !== ec[i]) begin
          n_fail++;
          $display("FAIL sweep sel=%0d vec=%0d: got cycles=%0d done=%b sum=%h cout=%b want %0d/1/%h/%b",
                   sel, i, nb, d, s, c, want_nb, es[i], ec[i]);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    test_reset();
    test_add_basic();
    test_wrap();
    test_back_to_back();
    test_busy_start_and_reset();
`ifdef CHUNK_ADDER_SUB_EN
    test_sub();
`else
    test_sub_ignored();
`endif
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
